// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, default opcodes and the
// 1149.1 next-state function used by the responder FSM.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SH_DR    = 4'd4,
        EX1_DR   = 4'd5,
        PAUSE_DR = 4'd6,
        EX2_DR   = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SH_IR    = 4'd11,
        EX1_IR   = 4'd12,
        PAUSE_IR = 4'd13,
        EX2_IR   = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_e;

    localparam logic [3:0] OP_IDCODE_DEF = 4'b0001;
    localparam logic [3:0] OP_USER_DEF   = 4'b1000;

    function automatic tap_state_e tap_next(
        input tap_state_e s,
        input logic       tms
    );
        tap_state_e n;
        unique case (s)
            TLR:      n = tms ? TLR      : RTI;
            RTI:      n = tms ? SEL_DR   : RTI;
            SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   n = tms ? EX1_DR   : SH_DR;
            SH_DR:    n = tms ? EX1_DR   : SH_DR;
            EX1_DR:   n = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: n = tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   n = tms ? UPD_DR   : SH_DR;
            UPD_DR:   n = tms ? SEL_DR   : RTI;
            SEL_IR:   n = tms ? TLR      : CAP_IR;
            CAP_IR:   n = tms ? EX1_IR   : SH_IR;
            SH_IR:    n = tms ? EX1_IR   : SH_IR;
            EX1_IR:   n = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: n = tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   n = tms ? UPD_IR   : SH_IR;
            UPD_IR:   n = tms ? SEL_DR   : RTI;
            default:  n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_pin_sync.sv
// Brings tck/tms/tdi/trst_n into the clk domain and derives tck edge strobes.
// Ports: clk/rst in; raw pins in; tck_rise/tck_fall strobes, synced tms/tdi/trst_n out.
module jtag_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    input  logic trst_n,
    output logic tck_rise,
    output logic tck_fall,
    output logic tms_s,
    output logic tdi_s,
    output logic trst_n_s
);

    logic [SYNC_STAGES-1:0] tck_q;
    logic [SYNC_STAGES-1:0] tms_q;
    logic [SYNC_STAGES-1:0] tdi_q;
    logic [SYNC_STAGES-1:0] trst_q;
    logic                   tck_prev_q;

    // trst sync resets low so the TAP stays reset until the pin is seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            tck_q      <= '0;
            tms_q      <= '0;
            tdi_q      <= '0;
            trst_q     <= '0;
            tck_prev_q <= 1'b0;
        end else begin
            tck_q      <= {tck_q[SYNC_STAGES-2:0], tck};
            tms_q      <= {tms_q[SYNC_STAGES-2:0], tms};
            tdi_q      <= {tdi_q[SYNC_STAGES-2:0], tdi};
            trst_q     <= {trst_q[SYNC_STAGES-2:0], trst_n};
            tck_prev_q <= tck_q[SYNC_STAGES-1];
        end
    end

    assign tck_rise = tck_q[SYNC_STAGES-1] & ~tck_prev_q;
    assign tck_fall = ~tck_q[SYNC_STAGES-1] & tck_prev_q;
    assign tms_s    = tms_q[SYNC_STAGES-1];
    assign tdi_s    = tdi_q[SYNC_STAGES-1];
    assign trst_n_s = trst_q[SYNC_STAGES-1];

endmodule

// File: rtl/jtag_tap_responder.sv
// Target-side 1149.1 TAP with IR, BYPASS, IDCODE and one USER register.
// Ports: clk/rst, JTAG pins in, tdo/tdo_oe/tap_state out, USER capture/parallel/update.
module jtag_tap_responder
    import jtag_pkg::*;
#(
    parameter int                IR_LEN      = 4,
    parameter logic [31:0]       IDCODE_VAL  = 32'h1BB1_0001,
    parameter int                USER_LEN    = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [IR_LEN-1:0] OP_IDCODE   = IR_LEN'(OP_IDCODE_DEF),
    parameter logic [IR_LEN-1:0] OP_USER     = IR_LEN'(OP_USER_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tck,
    input  logic                tms,
    input  logic                tdi,
    input  logic                trst_n,
    output logic                tdo,
    output logic                tdo_oe,
    output logic [3:0]          tap_state,
    input  logic [USER_LEN-1:0] user_capture,
    output logic [USER_LEN-1:0] user_dr,
    output logic                user_update
);

    logic tck_rise, tck_fall, tms_s, tdi_s, trst_n_s;

    jtag_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .tck      (tck),
        .tms      (tms),
        .tdi      (tdi),
        .trst_n   (trst_n),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall),
        .tms_s    (tms_s),
        .tdi_s    (tdi_s),
        .trst_n_s (trst_n_s)
    );

    tap_state_e          state_q, state_d;
    logic [IR_LEN-1:0]   ir_q, ir_d;
    logic [IR_LEN-1:0]   ir_sh_q, ir_sh_d;
    logic                byp_q, byp_d;
    logic [31:0]         id_sh_q, id_sh_d;
    logic [USER_LEN-1:0] usr_sh_q, usr_sh_d;
    logic [USER_LEN-1:0] user_dr_q, user_dr_d;
    logic                upd_q, upd_d;
    logic                tdo_q, tdo_d;
    logic                oe_q, oe_d;

    logic sel_id, sel_usr, dr_lsb, in_ir;

    assign sel_id  = (ir_q == OP_IDCODE);
    assign sel_usr = (ir_q == OP_USER);
    assign in_ir   = (state_q >= SEL_IR);

    always_comb begin
        dr_lsb = byp_q;
        unique case (1'b1)
            sel_id:  dr_lsb = id_sh_q[0];
            sel_usr: dr_lsb = usr_sh_q[0];
            default: dr_lsb = byp_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TLR;
            ir_q      <= OP_IDCODE;
            ir_sh_q   <= '0;
            byp_q     <= 1'b0;
            id_sh_q   <= '0;
            usr_sh_q  <= '0;
            user_dr_q <= '0;
            upd_q     <= 1'b0;
            tdo_q     <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            ir_sh_q   <= ir_sh_d;
            byp_q     <= byp_d;
            id_sh_q   <= id_sh_d;
            usr_sh_q  <= usr_sh_d;
            user_dr_q <= user_dr_d;
            upd_q     <= upd_d;
            tdo_q     <= tdo_d;
            oe_q      <= oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        ir_sh_d   = ir_sh_q;
        byp_d     = byp_q;
        id_sh_d   = id_sh_q;
        usr_sh_d  = usr_sh_q;
        user_dr_d = user_dr_q;
        upd_d     = 1'b0;
        tdo_d     = tdo_q;
        oe_d      = oe_q;

        // Capture/shift act on the state being left at the rising edge.
        if (tck_rise) begin
            state_d = tap_next(state_q, tms_s);
            case (state_q)
                CAP_IR: ir_sh_d = IR_LEN'(2'b01);
                SH_IR:  ir_sh_d = {tdi_s, ir_sh_q[IR_LEN-1:1]};
                CAP_DR: begin
                    unique case (1'b1)
                        sel_id:  id_sh_d  = IDCODE_VAL;
                        sel_usr: usr_sh_d = user_capture;
                        default: byp_d    = 1'b0;
                    endcase
                end
                SH_DR: begin
                    unique case (1'b1)
                        sel_id:  id_sh_d = {tdi_s, id_sh_q[31:1]};
                        sel_usr: usr_sh_d = (usr_sh_q >> 1)
                                 | (USER_LEN'(tdi_s) << (USER_LEN - 1));
                        default: byp_d = tdi_s;
                    endcase
                end
                default: ;
            endcase
        end

        if (tck_fall) begin
            case (state_q)
                UPD_IR: ir_d = ir_sh_q;
                UPD_DR: begin
                    if (sel_usr) begin
                        user_dr_d = usr_sh_q;
                        upd_d     = 1'b1;
                    end
                end
                default: ;
            endcase
            tdo_d = in_ir ? ir_sh_q[0] : dr_lsb;
            oe_d  = (state_q == SH_IR) || (state_q == SH_DR);
        end

        if (state_q == TLR) begin
            ir_d = OP_IDCODE;
        end

        // TAP reset overrides any coincident edge; user_dr survives it.
        if (!trst_n_s) begin
            state_d  = TLR;
            ir_d     = OP_IDCODE;
            ir_sh_d  = '0;
            byp_d    = 1'b0;
            id_sh_d  = '0;
            usr_sh_d = '0;
            upd_d    = 1'b0;
            tdo_d    = 1'b0;
            oe_d     = 1'b0;
        end
    end

    assign tdo         = tdo_q;
    assign tdo_oe      = oe_q;
    assign tap_state   = state_q;
    assign user_dr     = user_dr_q;
    assign user_update = upd_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: scans, reset and FSM walk.
// Drives slow tck against a fast clk and checks tdo streams and state.
module tb_jtag_tap_responder;

    logic       clk = 1'b0;
    logic       rst, tck, tms, tdi, trst_n;
    logic       tdo, tdo_oe;
    logic [3:0] tap_state;
    logic [7:0] user_capture, user_dr;
    logic       user_update;

    always #5 clk = ~clk;

    jtag_tap_responder dut (
        .clk          (clk),
        .rst          (rst),
        .tck          (tck),
        .tms          (tms),
        .tdi          (tdi),
        .trst_n       (trst_n),
        .tdo          (tdo),
        .tdo_oe       (tdo_oe),
        .tap_state    (tap_state),
        .user_capture (user_capture),
        .user_dr      (user_dr),
        .user_update  (user_update)
    );

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    logic upd_prev = 1'b0;
    logic dbl = 1'b0;

    int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int plen [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
    int pbit [16] = '{0, 0, 2, 2, 2, 10, 10, 42, 26, 6, 6, 6, 22, 22, 86, 54};

    always @(negedge clk) begin
        if (user_update) upd_cnt++;
        if (user_update && upd_prev) dbl = 1'b1;
        upd_prev = user_update;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tck_cycle(input logic m, input logic d,
                             output logic o, output logic e);
        @(negedge clk);
        tms = m;
        tdi = d;
        repeat (2) @(negedge clk);
        o = tdo;
        e = tdo_oe;
        tck = 1'b1;
        repeat (4) @(negedge clk);
        tck = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic tp(input logic m);
        logic o, e;
        tck_cycle(m, 1'b0, o, e);
    endtask

    task automatic to_tlr();
        for (int i = 0; i < 5; i++) tp(1'b1);
    endtask

    // From RTI: scan n bits of data LSB first into IR or DR, back to RTI.
    task automatic scan(input logic ir, input logic [31:0] data, input int n,
                        output logic [31:0] out, output logic oe_ok);
        logic o, e;
        out = '0;
        oe_ok = 1'b1;
        tp(1'b1);
        if (ir) tp(1'b1);
        tp(1'b0);
        tck_cycle(1'b0, 1'b0, o, e);
        if (e) oe_ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, data[i], o, e);
            out[i] = o;
            if (!e) oe_ok = 1'b0;
        end
        tck_cycle(1'b1, 1'b0, o, e);
        if (e) oe_ok = 1'b0;
        tp(1'b0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] out;
        logic ok, o, e;
        int c0, m;

        rst = 1'b1;
        tck = 1'b0;
        tms = 1'b1;
        tdi = 1'b0;
        trst_n = 1'b1;
        user_capture = 8'h00;
        repeat (4) @(negedge clk);
        check("rst_state", 32'(tap_state), 32'd0);
        check("rst_tdo", 32'(tdo), 32'd0);
        check("rst_oe", 32'(tdo_oe), 32'd0);
        check("rst_udr", 32'(user_dr), 32'd0);
        check("rst_upd", 32'(user_update), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        to_tlr();
        check("tlr", 32'(tap_state), 32'd0);
        tp(1'b0);
        check("rti", 32'(tap_state), 32'd1);

        scan(1'b0, 32'h0, 32, out, ok);
        check("idcode", out, 32'h1BB1_0001);
        check("idcode_oe", 32'(ok), 32'd1);
        check("idcode_rti", 32'(tap_state), 32'd1);

        scan(1'b1, 32'hF, 4, out, ok);
        check("capir_byp", out, 32'h1);
        check("ir_oe", 32'(ok), 32'd1);
        scan(1'b0, 32'h0A5, 9, out, ok);
        check("bypass", out, 32'h14A);

        user_capture = 8'hC3;
        scan(1'b1, 32'h8, 4, out, ok);
        c0 = upd_cnt;
        scan(1'b0, 32'h3C, 8, out, ok);
        check("user_cap", out, 32'hC3);
        check("user_dr", 32'(user_dr), 32'h3C);
        check("user_pulses", 32'(upd_cnt - c0), 32'd1);

        scan(1'b1, 32'h0, 4, out, ok);
        check("capir_b0", 32'(out[0]), 32'd1);
        check("capir_b1", 32'(out[1]), 32'd0);

        scan(1'b1, 32'h8, 4, out, ok);
        tp(1'b1);
        tp(1'b0);
        tp(1'b0);
        check("in_shdr", 32'(tap_state), 32'd4);
        for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1, o, e);
        c0 = upd_cnt;
        @(negedge clk);
        trst_n = 1'b0;
        repeat (3) @(negedge clk);
        trst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("trst_state", 32'(tap_state), 32'd0);
        check("trst_oe", 32'(tdo_oe), 32'd0);
        check("trst_udr", 32'(user_dr), 32'h3C);
        check("trst_noupd", 32'(upd_cnt - c0), 32'd0);
        tp(1'b0);
        scan(1'b0, 32'h0, 32, out, ok);
        check("trst_ir", out, 32'h1BB1_0001);

        for (int s = 0; s < 16; s++) begin
            to_tlr();
            for (int b = 0; b < plen[s]; b++) tp(pbit[s][b]);
            check($sformatf("goto%0d", s), 32'(tap_state), 32'(s));
            to_tlr();
            check($sformatf("ret%0d", s), 32'(tap_state), 32'd0);
        end

        m = 0;
        for (int i = 0; i < 1000; i++) begin
            logic bm, bd;
            bm = 1'($urandom_range(0, 1));
            bd = 1'($urandom_range(0, 1));
            @(negedge clk);
            tms = bm;
            tdi = bd;
            @(negedge clk);
            tck = 1'b1;
            repeat (3) @(negedge clk);
            tck = 1'b0;
            repeat (3) @(negedge clk);
            m = bm ? nx1[m] : nx0[m];
            check("walk", 32'(tap_state), 32'(m));
        end

        check("no_dbl_upd", 32'(dbl), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst2_udr", 32'(user_dr), 32'd0);
        check("rst2_state", 32'(tap_state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
